// File: rtl/clock_alarm_controller.sv
// clock_alarm_controller: prescaler, h/m/s with carry, alarm time, alarm FSM with snooze and ring timeout, buzzer gate
module clock_alarm_controller #(
  parameter int TICK_DIV = 31_500_000,
  parameter int BUZZ_HALF = 5_000,
  parameter int SNOOZE_SEC = 300,
  parameter int RING_TIMEOUT_SEC = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_pulse,
  input  logic       min_pulse,
  input  logic       hour_pulse,
  input  logic       al_pulse,
  input  logic       al_toggle_pulse,
  input  logic       snooze_pulse,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [3:0] hours,
  output logic [5:0] al_minutes,
  output logic [3:0] al_hours,
  output logic       al_on,
  output logic       ringing,
  output logic       sec_phase,
  output logic       buzzer_out
);
  localparam int CW = $clog2(TICK_DIV + 1);
  localparam int BW = $clog2(2 * BUZZ_HALF + 1);
  localparam int TMAX = (SNOOZE_SEC > RING_TIMEOUT_SEC) ? SNOOZE_SEC : RING_TIMEOUT_SEC;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CHALF = CW'(TICK_DIV / 2);
  localparam logic [BW-1:0] BMAX = BW'(2 * BUZZ_HALF - 1);
  localparam logic [BW-1:0] BMID = BW'(BUZZ_HALF - 1);
  localparam logic [TW-1:0] T_RING = TW'(RING_TIMEOUT_SEC);
  localparam logic [TW-1:0] T_SNZ = TW'(SNOOZE_SEC);
  localparam logic [TW-1:0] T_ONE = TW'(1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] RINGING = 2'd2;
  localparam logic [1:0] SNOOZED = 2'd3;

  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [1:0] state, state_n;
  logic [5:0] sec_n, min_n, alm_n;
  logic [3:0] hr_n, alh_n;
  logic tick, sec_c, min_c, al_wrap, match, match_d, trig, buzz, buzz_n, sp_n;

  assign al_on = state != IDLE;
  assign ringing = state == RINGING;

  // an adjust pulse into a field swallows any carry arriving there in the same cycle
  always_comb begin
    tick = cnt == CMAX;
    cnt_n = (sec_pulse || tick) ? '0 : cnt + 1'b1;
    sp_n = cnt_n < CHALF;
    sec_c = !sec_pulse && tick && seconds == 6'd59;
    sec_n = (sec_pulse || tick) ? ((seconds == 6'd59) ? 6'd0 : seconds + 6'd1) : seconds;
    min_c = sec_c && !min_pulse && minutes == 6'd59;
    min_n = (min_pulse || sec_c) ? ((minutes == 6'd59) ? 6'd0 : minutes + 6'd1) : minutes;
    hr_n = (hour_pulse || min_c) ? ((hours == 4'd11) ? 4'd0 : hours + 4'd1) : hours;
    al_wrap = al_minutes == 6'd50;
    alm_n = al_pulse ? (al_wrap ? 6'd0 : al_minutes + 6'd10) : al_minutes;
    alh_n = (al_pulse && al_wrap) ? ((al_hours == 4'd11) ? 4'd0 : al_hours + 4'd1) : al_hours;
    match = hours == al_hours && minutes == al_minutes && seconds == 6'd0;
    trig = match && !match_d;
    bcnt_n = (bcnt == BMAX) ? '0 : bcnt + 1'b1;
    buzz_n = buzz ^ (bcnt == BMID || bcnt == BMAX);
  end

  always_comb begin
    state_n = state;
    tmr_n = tmr;
    case (state)
      IDLE: if (al_toggle_pulse) state_n = ARMED;
      ARMED:
        if (al_toggle_pulse) state_n = IDLE;
        else if (trig) begin
          state_n = RINGING;
          tmr_n = T_RING;
        end
      RINGING:
        if (al_toggle_pulse) state_n = IDLE;
        else if (snooze_pulse) begin
          state_n = SNOOZED;
          tmr_n = T_SNZ;
        end else if (tick) begin
          state_n = (tmr == T_ONE) ? ARMED : RINGING;
          tmr_n = tmr - 1'b1;
        end
      default:
        if (al_toggle_pulse) state_n = IDLE;
        else if (tick) begin
          state_n = (tmr == T_ONE) ? RINGING : SNOOZED;
          tmr_n = (tmr == T_ONE) ? T_RING : tmr - 1'b1;
        end
    endcase
  end

  // sec_phase and buzzer_out are registered from next-cycle values so they line up with the state they describe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      bcnt <= '0;
      tmr <= '0;
      state <= IDLE;
      seconds <= '0;
      minutes <= '0;
      hours <= '0;
      al_minutes <= '0;
      al_hours <= '0;
      match_d <= 1'b0;
      buzz <= 1'b0;
      sec_phase <= 1'b0;
      buzzer_out <= 1'b0;
    end else begin
      cnt <= cnt_n;
      bcnt <= bcnt_n;
      tmr <= tmr_n;
      state <= state_n;
      seconds <= sec_n;
      minutes <= min_n;
      hours <= hr_n;
      al_minutes <= alm_n;
      al_hours <= alh_n;
      match_d <= match;
      buzz <= buzz_n;
      sec_phase <= sp_n;
      buzzer_out <= (state_n == RINGING) && sp_n && buzz_n;
    end
  end
endmodule

// File: tb/tb_clock_alarm_controller.sv
// tb_clock_alarm_controller: directed and random stimulus checked every cycle against a behavioural clock/alarm model
module tb_clock_alarm_controller;
  localparam int TD = 4, BH = 3, SN = 3, RT = 2;
  localparam int S_IDLE = 0, S_ARMED = 1, S_RING = 2, S_SNZ = 3;
  localparam logic [5:0] P_SEC = 6'b100000, P_MIN = 6'b010000, P_HR = 6'b001000;
  localparam logic [5:0] P_AL = 6'b000100, P_TG = 6'b000010, P_SZ = 6'b000001;

  logic clk = 0, reset = 1;
  logic sec_pulse = 0, min_pulse = 0, hour_pulse = 0, al_pulse = 0, al_toggle_pulse = 0, snooze_pulse = 0;
  logic [5:0] seconds, minutes, al_minutes;
  logic [3:0] hours, al_hours;
  logic al_on, ringing, sec_phase, buzzer_out;
  int checks = 0, errors = 0;
  int m_cnt = 0, m_sec = 0, m_min = 0, m_hr = 0, m_am = 0, m_ah = 0, m_st = 0, m_tm = 0, m_k = 0;
  bit m_md = 0, m_run = 0;

  clock_alarm_controller #(.TICK_DIV(TD), .BUZZ_HALF(BH), .SNOOZE_SEC(SN), .RING_TIMEOUT_SEC(RT)) dut (
    .clk(clk), .reset(reset), .sec_pulse(sec_pulse), .min_pulse(min_pulse), .hour_pulse(hour_pulse),
    .al_pulse(al_pulse), .al_toggle_pulse(al_toggle_pulse), .snooze_pulse(snooze_pulse),
    .seconds(seconds), .minutes(minutes), .hours(hours), .al_minutes(al_minutes), .al_hours(al_hours),
    .al_on(al_on), .ringing(ringing), .sec_phase(sec_phase), .buzzer_out(buzzer_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin : model
    bit tk, cs, cm, mt;
    int nst, ntm;
    if (reset) begin
      m_cnt <= 0; m_sec <= 0; m_min <= 0; m_hr <= 0; m_am <= 0; m_ah <= 0;
      m_st <= S_IDLE; m_tm <= 0; m_k <= 0; m_md <= 0; m_run <= 0;
    end else begin
      tk = m_cnt == TD - 1;
      cs = !sec_pulse && tk && m_sec == 59;
      cm = cs && !min_pulse && m_min == 59;
      mt = m_hr == m_ah && m_min == m_am && m_sec == 0;
      nst = m_st;
      ntm = m_tm;
      if (al_toggle_pulse) nst = (m_st == S_IDLE) ? S_ARMED : S_IDLE;
      else if (m_st == S_ARMED && mt && !m_md) begin nst = S_RING; ntm = RT; end
      else if (m_st == S_RING && snooze_pulse) begin nst = S_SNZ; ntm = SN; end
      else if ((m_st == S_RING || m_st == S_SNZ) && tk) begin
        if (m_tm == 1) begin nst = (m_st == S_RING) ? S_ARMED : S_RING; ntm = RT; end
        else ntm = m_tm - 1;
      end
      m_st <= nst;
      m_tm <= ntm;
      m_cnt <= (sec_pulse || tk) ? 0 : m_cnt + 1;
      m_sec <= (sec_pulse || tk) ? (m_sec + 1) % 60 : m_sec;
      m_min <= (min_pulse || cs) ? (m_min + 1) % 60 : m_min;
      m_hr <= (hour_pulse || cm) ? (m_hr + 1) % 12 : m_hr;
      m_am <= al_pulse ? (m_am + 10) % 60 : m_am;
      m_ah <= (al_pulse && m_am + 10 >= 60) ? (m_ah + 1) % 12 : m_ah;
      m_md <= mt;
      m_k <= m_k + 1;
      m_run <= 1;
    end
  end

  always @(negedge clk) begin
    chk("seconds", int'(seconds), m_sec);
    chk("minutes", int'(minutes), m_min);
    chk("hours", int'(hours), m_hr);
    chk("al_minutes", int'(al_minutes), m_am);
    chk("al_hours", int'(al_hours), m_ah);
    chk("al_on", int'(al_on), int'(m_st != S_IDLE));
    chk("ringing", int'(ringing), int'(m_st == S_RING));
    chk("sec_phase", int'(sec_phase), int'(m_run && m_cnt < TD / 2));
    chk("buzzer_out", int'(buzzer_out), int'(m_run && m_st == S_RING && m_cnt < TD / 2 && (m_k / BH) % 2 == 1));
  end

  task automatic cyc(input logic [5:0] p);
    {sec_pulse, min_pulse, hour_pulse, al_pulse, al_toggle_pulse, snooze_pulse} = p;
    @(posedge clk);
    #1;
    {sec_pulse, min_pulse, hour_pulse, al_pulse, al_toggle_pulse, snooze_pulse} = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc('0);
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    chk("rst_seconds", int'(seconds), 0);
    chk("rst_al_on", int'(al_on), 0);
    chk("rst_buzzer", int'(buzzer_out), 0);
    chk("rst_sec_phase", int'(sec_phase), 0);
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    for (int i = 0; i < 12 && m_hr != h; i++) cyc(P_HR);
    for (int i = 0; i < 60 && m_min != m; i++) cyc(P_MIN);
    for (int i = 0; i < 60 && m_sec != s; i++) cyc(P_SEC);
    chk("set_hours", int'(hours), h);
    chk("set_minutes", int'(minutes), m);
    chk("set_seconds", int'(seconds), s);
  endtask

  // alarm 01:10, time 01:09:59, armed; the next edge is the tick that reaches 01:10:00
  task automatic setup_alarm();
    do_reset();
    repeat (7) cyc(P_AL);
    set_time(1, 9, 59);
    cyc(P_TG);
    idle(2);
  endtask

  task automatic wait_ticks(input int n, input string nm, input int mid_ring);
    int t = 0;
    for (int i = 0; i < 40 && t < n; i++) begin
      bit w = m_cnt == TD - 1;
      cyc('0);
      if (w) begin
        t++;
        if (t < n) chk(nm, int'(ringing), mid_ring);
      end
    end
  endtask

  initial begin
    int seen, s0;
    bit found;
    logic [5:0] p;
    @(posedge clk);
    #1;
    do_reset();
    set_time(11, 59, 59);
    idle(3);
    chk("pre_roll_sec", int'(seconds), 59);
    idle(1);
    chk("roll_h", int'(hours), 0);
    chk("roll_m", int'(minutes), 0);
    chk("roll_s", int'(seconds), 0);
    chk("phase_c0", int'(sec_phase), 1);
    idle(1);
    chk("phase_c1", int'(sec_phase), 1);
    idle(1);
    chk("phase_c2", int'(sec_phase), 0);

    do_reset();
    for (int i = 1; i <= 6; i++) begin
      cyc(P_AL);
      chk("al_step_min", int'(al_minutes), (i * 10) % 60);
      chk("al_step_hr", int'(al_hours), (i == 6) ? 1 : 0);
    end
    repeat (60) cyc(P_AL);
    chk("al_h11", int'(al_hours), 11);
    chk("al_m0", int'(al_minutes), 0);
    repeat (6) cyc(P_AL);
    chk("al_wrap_h", int'(al_hours), 0);
    chk("al_wrap_m", int'(al_minutes), 0);

    setup_alarm();
    cyc('0);
    chk("hit_min", int'(minutes), 10);
    chk("hit_sec", int'(seconds), 0);
    chk("hit_ring_lat", int'(ringing), 0);
    cyc('0);
    chk("ring_on", int'(ringing), 1);
    chk("ring_al_on", int'(al_on), 1);
    seen = int'(buzzer_out);
    for (int i = 0; i < 4; i++) begin
      cyc('0);
      seen += int'(buzzer_out);
    end
    chk("buzz_seen", int'(seen > 0), 1);
    cyc(P_SZ);
    chk("snz_ringing", int'(ringing), 0);
    chk("snz_al_on", int'(al_on), 1);
    chk("snz_buzzer", int'(buzzer_out), 0);
    wait_ticks(SN, "snz_wait", 0);
    chk("snz_rering", int'(ringing), 1);
    wait_ticks(RT, "tmo_wait", 1);
    chk("tmo_ringing", int'(ringing), 0);
    chk("tmo_al_on", int'(al_on), 1);

    setup_alarm();
    idle(2);
    chk("edge_ring", int'(ringing), 1);
    cyc(P_TG);
    cyc(P_TG);
    idle(1);
    chk("edge_no_retrig", int'(ringing), 0);
    chk("edge_armed", int'(al_on), 1);

    setup_alarm();
    idle(2);
    cyc(P_TG | P_SZ);
    chk("tg_sz_al_on", int'(al_on), 0);
    chk("tg_sz_ringing", int'(ringing), 0);

    for (int i = 0; i < 8 && m_cnt != TD - 1; i++) cyc('0);
    s0 = m_sec;
    cyc(P_SEC);
    chk("sp_tick_once", int'(seconds), (s0 + 1) % 60);
    idle(TD - 1);
    chk("sp_tick_hold", int'(seconds), (s0 + 1) % 60);
    idle(1);
    chk("sp_tick_next", int'(seconds), (s0 + 2) % 60);

    setup_alarm();
    idle(2);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (buzzer_out) found = 1;
      else cyc('0);
    end
    chk("buzz_wait", int'(found), 1);
    #2;
    reset = 1;
    #1;
    chk("midring_buzzer", int'(buzzer_out), 0);
    chk("midring_state", int'(al_on), 0);
    @(posedge clk);
    #1;
    reset = 0;

    for (int i = 0; i < 3000; i++) begin
      if (i % 600 == 0) setup_alarm();
      if ($urandom_range(0, 299) == 0) do_reset();
      for (int b = 0; b < 6; b++) p[b] = $urandom_range(0, 15) == 0;
      cyc(p);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual running expected finished");
    $fatal(1);
  end
endmodule
